rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3, meaning consecutive denied cycles of port A before A is forced ahead of M (legal range 1..15).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port a_valid  input  1  ALU writeback request.
REQ-005 SHALL have port a_reg  input  5  ALU destination register.
REQ-006 SHALL have port a_data  input  32  ALU write value.
REQ-007 SHALL have port a_ready  output  1  ALU request accepted this cycle (combinational).
REQ-008 SHALL have port m_valid  input  1  load writeback request.
REQ-009 SHALL have port m_reg  input  5  load destination register.
REQ-010 SHALL have port m_data  input  32  load write value.
REQ-011 SHALL have port m_ready  output  1  load request accepted this cycle (combinational).
REQ-012 SHALL have port wr_hold  input  1  freeze: no acceptance while high.
REQ-013 SHALL have port reg_write_en  output  1  register-file write enable (registered).
REQ-014 SHALL have port write_reg  output  5  register-file write address (registered).
REQ-015 SHALL have port write_data  output  32  register-file write data (registered).
REQ-016 SHALL have port grant_src  output  1  source of the current write: 0=A, 1=M (registered).
REQ-017 SHALL have port force_a  output  1  high while FSM is in FORCE_A.

Function
REQ-018 SHALL accept a request when valid and ready are both high in the same cycle; at most one of a_ready/m_ready high per cycle.
REQ-019 SHALL drive a_ready = m_ready = 0 whenever wr_hold=1 or rst_n=0.
REQ-020 SHALL, in state NORMAL, give M priority: m_ready=m_valid; a_ready=a_valid & ~m_valid.
REQ-021 SHALL, in state FORCE_A, give A priority: a_ready=a_valid; m_ready=m_valid & ~a_valid.
REQ-022 SHALL keep a 4-bit starve counter: +1 on each cycle with a_valid=1, a_ready=0, wr_hold=0; cleared on A acceptance or a_valid=0; held while wr_hold=1; saturates at STARVE_LIMIT.
REQ-023 SHALL transition NORMAL->FORCE_A at the edge where the counter's next value equals STARVE_LIMIT.
REQ-024 SHALL transition FORCE_A->NORMAL at the edge where A is accepted or a_valid=0; wr_hold=1 holds the state.
REQ-025 SHALL, at the edge of an acceptance, load write_reg/write_data/grant_src from the winner and set reg_write_en=1 unless the winner's register is 0 (write to $0 dropped: request still accepted, reg_write_en=0).
REQ-026 SHALL set reg_write_en=0 at any edge with no acceptance; write_reg/write_data/grant_src hold their prior values.
REQ-027 SHALL sustain one accepted write per cycle (fixed latency: accept at edge N -> reg_write_en high for cycle N..N+1; register file commits at edge N+1).
REQ-028 SHALL treat both requesters targeting the same register like any other conflict: loser waits; writes commit in acceptance order.
REQ-029 SHALL require requesters to hold valid/reg/data stable until accepted; the block SHALL not buffer unaccepted requests.

Reset
REQ-030 SHALL, on a clk edge with rst_n=0, set reg_write_en=0, write_reg=0, write_data=0, grant_src=0, force_a=0, state NORMAL, starve counter 0.
REQ-031 SHALL, if reset arrives mid-stream, discard any write not yet presented on reg_write_en; a request seen during reset is not accepted and must be re-presented.

Verification
REQ-032 SHALL verify: A only, a_reg=1, a_data=42 -> a_ready=1; next cycle reg_write_en=1, write_reg=1, write_data=42, grant_src=0.
REQ-033 SHALL verify: a_valid and m_valid together (a_reg=2/5, m_reg=3/7) in NORMAL -> M accepted first (write_reg=3, data 7), A next cycle (write_reg=2, data 5).
REQ-034 SHALL verify: STARVE_LIMIT=3, m_valid held high, a_valid high -> A denied 3 cycles, force_a=1, A accepted 4th cycle, force_a=0 after.
REQ-035 SHALL verify: m_reg=0, m_data=99 -> m_ready=1, reg_write_en stays 0; subsequent read of $0 returns 0.
REQ-036 SHALL verify: wr_hold=1 for 2 cycles with both valid -> both readies 0, reg_write_en=0, starve counter unchanged; release -> normal priority resumes.
REQ-037 SHALL verify: rst_n=0 asserted while reg_write_en=1 -> next edge all outputs 0, state NORMAL, no acceptance until rst_n=1.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Two-source register-file write arbiter: loads (M) win by default, and a
// starvation counter temporarily gives the ALU (A) priority.
module rf_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [4:0]  a_reg,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        m_valid,
  input  logic [4:0]  m_reg,
  input  logic [31:0] m_data,
  output logic        m_ready,
  input  logic        wr_hold,
  output logic        reg_write_en,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        grant_src,
  output logic        force_a
);

  // state   | meaning
  // NORMAL  | M has priority, A waits while M is valid
  // FORCE_A | A starved too long, A has priority for one acceptance
  typedef enum logic {
    NORMAL  = 1'b0,
    FORCE_A = 1'b1
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state, state_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       a_acc, m_acc;

  // Readies are never raised during reset so a request seen then is not consumed.
  always_comb begin
    a_ready = 1'b0;
    m_ready = 1'b0;
    if (rst_n && !wr_hold) begin
      if (state == NORMAL) begin
        m_ready = m_valid;
        a_ready = a_valid & ~m_valid;
      end else begin
        a_ready = a_valid;
        m_ready = m_valid & ~a_valid;
      end
    end
  end

  assign a_acc   = a_valid & a_ready;
  assign m_acc   = m_valid & m_ready;
  assign force_a = (state == FORCE_A);

  always_comb begin
    starve_nxt = starve_cnt;
    state_nxt  = state;
    if (!wr_hold) begin
      if (a_valid && !a_ready)
        starve_nxt = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 4'd1;
      else
        starve_nxt = 4'd0;
      case (state)
        NORMAL:  if (starve_nxt == LIMIT) state_nxt = FORCE_A;
        FORCE_A: if (a_acc || !a_valid) state_nxt = NORMAL;
        default: state_nxt = NORMAL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= NORMAL;
      starve_cnt   <= 4'd0;
      reg_write_en <= 1'b0;
      write_reg    <= 5'd0;
      write_data   <= 32'd0;
      grant_src    <= 1'b0;
    end else begin
      state        <= state_nxt;
      starve_cnt   <= starve_nxt;
      reg_write_en <= 1'b0;
      // Writes to $0 are still accepted but never reach the register file.
      if (m_acc) begin
        write_reg    <= m_reg;
        write_data   <= m_data;
        grant_src    <= 1'b1;
        reg_write_en <= (m_reg != 5'd0);
      end else if (a_acc) begin
        write_reg    <= a_reg;
        write_data   <= a_data;
        grant_src    <= 1'b0;
        reg_write_en <= (a_reg != 5'd0);
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter with a tiny register-file
// model fed by the write port.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, m_valid, wr_hold;
  logic [4:0]  a_reg, m_reg;
  logic [31:0] a_data, m_data;
  logic        a_ready, m_ready, reg_write_en, grant_src, force_a;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] rf [32];

  int total = 0;
  int bad   = 0;

  rf_write_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .m_valid(m_valid), .m_reg(m_reg), .m_data(m_data), .m_ready(m_ready),
    .wr_hold(wr_hold),
    .reg_write_en(reg_write_en), .write_reg(write_reg), .write_data(write_data),
    .grant_src(grant_src), .force_a(force_a)
  );

  always #5 clk = ~clk;

  // Register file behind the arbiter; $0 is hardwired to zero on read.
  always @(posedge clk)
    if (reg_write_en && write_reg != 5'd0) rf[write_reg] <= write_data;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
    a_valid = av; a_reg = ar; a_data = ad;
    m_valid = mv; m_reg = mr; m_data = md;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_hold = 1'b0;
    drive(1'b1, 5'd4, 32'd11, 1'b1, 5'd5, 32'd12);
    total++; if (a_ready !== 1'b0 || m_ready !== 1'b0) begin bad++;
      $display("FAIL reset_ready: a=%b m=%b want 0 0", a_ready, m_ready); end
    step();
    step();
    total++; if (reg_write_en !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'd0) begin bad++;
      $display("FAIL reset_outputs: we=%b reg=%0d data=%0d want 0 0 0", reg_write_en, write_reg, write_data); end
    total++; if (grant_src !== 1'b0 || force_a !== 1'b0) begin bad++;
      $display("FAIL reset_grant_force: grant=%b force=%b want 0 0", grant_src, force_a); end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_a_only();
    drive(1'b1, 5'd1, 32'd42, 1'b0, 5'd0, 32'd0);
    total++; if (a_ready !== 1'b1 || m_ready !== 1'b0) begin bad++;
      $display("FAIL a_only_ready: a=%b m=%b want 1 0", a_ready, m_ready); end
    step();
    total++; if (reg_write_en !== 1'b1 || write_reg !== 5'd1 || write_data !== 32'd42 || grant_src !== 1'b0) begin bad++;
      $display("FAIL a_only_write: we=%b reg=%0d data=%0d grant=%b want 1 1 42 0", reg_write_en, write_reg, write_data, grant_src); end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    total++; if (reg_write_en !== 1'b0 || write_reg !== 5'd1 || write_data !== 32'd42) begin bad++;
      $display("FAIL idle_hold: we=%b reg=%0d data=%0d want 0 1 42", reg_write_en, write_reg, write_data); end
  endtask

  task automatic test_conflict();
    drive(1'b1, 5'd2, 32'd5, 1'b1, 5'd3, 32'd7);
    total++; if (a_ready !== 1'b0 || m_ready !== 1'b1) begin bad++;
      $display("FAIL conflict_ready: a=%b m=%b want 0 1", a_ready, m_ready); end
    step();
    total++; if (reg_write_en !== 1'b1 || write_reg !== 5'd3 || write_data !== 32'd7 || grant_src !== 1'b1) begin bad++;
      $display("FAIL conflict_m_first: we=%b reg=%0d data=%0d grant=%b want 1 3 7 1", reg_write_en, write_reg, write_data, grant_src); end
    drive(1'b1, 5'd2, 32'd5, 1'b0, 5'd0, 32'd0);
    total++; if (a_ready !== 1'b1) begin bad++;
      $display("FAIL conflict_a_ready: a=%b want 1", a_ready); end
    step();
    total++; if (reg_write_en !== 1'b1 || write_reg !== 5'd2 || write_data !== 32'd5 || grant_src !== 1'b0) begin bad++;
      $display("FAIL conflict_a_next: we=%b reg=%0d data=%0d grant=%b want 1 2 5 0", reg_write_en, write_reg, write_data, grant_src); end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
  endtask

  task automatic test_starve();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd6, 32'd66, 1'b1, 5'(20 + i), 32'(200 + i));
      total++; if (a_ready !== 1'b0 || m_ready !== 1'b1 || force_a !== 1'b0) begin bad++;
        $display("FAIL starve_deny%0d: a=%b m=%b force=%b want 0 1 0", i, a_ready, m_ready, force_a); end
      step();
      total++; if (write_reg !== 5'(20 + i) || grant_src !== 1'b1) begin bad++;
        $display("FAIL starve_m_write%0d: reg=%0d grant=%b want %0d 1", i, write_reg, grant_src, 20 + i); end
    end
    drive(1'b1, 5'd6, 32'd66, 1'b1, 5'd23, 32'd203);
    total++; if (force_a !== 1'b1 || a_ready !== 1'b1 || m_ready !== 1'b0) begin bad++;
      $display("FAIL starve_force: force=%b a=%b m=%b want 1 1 0", force_a, a_ready, m_ready); end
    step();
    total++; if (reg_write_en !== 1'b1 || write_reg !== 5'd6 || write_data !== 32'd66 || grant_src !== 1'b0) begin bad++;
      $display("FAIL starve_a_write: we=%b reg=%0d data=%0d grant=%b want 1 6 66 0", reg_write_en, write_reg, write_data, grant_src); end
    total++; if (force_a !== 1'b0) begin bad++;
      $display("FAIL starve_release: force=%b want 0", force_a); end
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd23, 32'd203);
    step();
    total++; if (write_reg !== 5'd23 || grant_src !== 1'b1) begin bad++;
      $display("FAIL starve_m_after: reg=%0d grant=%b want 23 1", write_reg, grant_src); end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
  endtask

  task automatic test_zero_reg();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'd99);
    total++; if (m_ready !== 1'b1) begin bad++;
      $display("FAIL zero_ready: m=%b want 1", m_ready); end
    step();
    total++; if (reg_write_en !== 1'b0) begin bad++;
      $display("FAIL zero_we: we=%b want 0", reg_write_en); end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    total++; if (rf[0] !== 32'd0) begin bad++;
      $display("FAIL zero_read: rf0=%0d want 0", rf[0]); end
  endtask

  task automatic test_hold();
    // One denied cycle before the hold leaves the starve count at 1.
    drive(1'b1, 5'd8, 32'd80, 1'b1, 5'd9, 32'd90);
    step();
    total++; if (write_reg !== 5'd9 || reg_write_en !== 1'b1) begin bad++;
      $display("FAIL hold_pre: reg=%0d we=%b want 9 1", write_reg, reg_write_en); end
    wr_hold = 1'b1;
    drive(1'b1, 5'd8, 32'd80, 1'b1, 5'd10, 32'd91);
    for (int i = 0; i < 2; i++) begin
      total++; if (a_ready !== 1'b0 || m_ready !== 1'b0) begin bad++;
        $display("FAIL hold_ready%0d: a=%b m=%b want 0 0", i, a_ready, m_ready); end
      step();
      total++; if (reg_write_en !== 1'b0 || write_reg !== 5'd9 || force_a !== 1'b0) begin bad++;
        $display("FAIL hold_out%0d: we=%b reg=%0d force=%b want 0 9 0", i, reg_write_en, write_reg, force_a); end
    end
    wr_hold = 1'b0;
    #1;
    total++; if (m_ready !== 1'b1 || a_ready !== 1'b0) begin bad++;
      $display("FAIL hold_resume: a=%b m=%b want 0 1", a_ready, m_ready); end
    step();
    total++; if (write_reg !== 5'd10 || grant_src !== 1'b1 || force_a !== 1'b0) begin bad++;
      $display("FAIL hold_m_after: reg=%0d grant=%b force=%b want 10 1 0", write_reg, grant_src, force_a); end
    drive(1'b1, 5'd8, 32'd80, 1'b1, 5'd11, 32'd92);
    step();
    total++; if (force_a !== 1'b1 || a_ready !== 1'b1) begin bad++;
      $display("FAIL hold_count_kept: force=%b a=%b want 1 1", force_a, a_ready); end
    drive(1'b1, 5'd8, 32'd80, 1'b1, 5'd12, 32'd93);
    step();
    total++; if (write_reg !== 5'd8 || write_data !== 32'd80 || grant_src !== 1'b0) begin bad++;
      $display("FAIL hold_a_forced: reg=%0d data=%0d grant=%b want 8 80 0", write_reg, write_data, grant_src); end
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'd93);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(13 + i), 32'(1000 * (i + 1)), 1'b0, 5'd0, 32'd0);
      step();
      total++; if (reg_write_en !== 1'b1 || write_reg !== 5'(13 + i) || write_data !== 32'(1000 * (i + 1))) begin bad++;
        $display("FAIL b2b%0d: we=%b reg=%0d data=%0d want 1 %0d %0d", i, reg_write_en, write_reg, write_data, 13 + i, 1000 * (i + 1)); end
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    total++; if (rf[15] !== 32'd3000) begin bad++;
      $display("FAIL b2b_commit: rf15=%0d want 3000", rf[15]); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 5'd17, 32'h55, 1'b0, 5'd0, 32'd0);
    step();
    total++; if (reg_write_en !== 1'b1 || write_reg !== 5'd17) begin bad++;
      $display("FAIL rmid_pre: we=%b reg=%0d want 1 17", reg_write_en, write_reg); end
    rst_n = 1'b0;
    drive(1'b1, 5'd18, 32'h66, 1'b1, 5'd19, 32'h77);
    total++; if (a_ready !== 1'b0 || m_ready !== 1'b0) begin bad++;
      $display("FAIL rmid_ready: a=%b m=%b want 0 0", a_ready, m_ready); end
    step();
    total++; if (reg_write_en !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'd0 || grant_src !== 1'b0 || force_a !== 1'b0) begin bad++;
      $display("FAIL rmid_out: we=%b reg=%0d data=%0d grant=%b force=%b want all 0", reg_write_en, write_reg, write_data, grant_src, force_a); end
    step();
    total++; if (reg_write_en !== 1'b0) begin bad++;
      $display("FAIL rmid_no_accept: we=%b want 0", reg_write_en); end
    rst_n = 1'b1;
    drive(1'b1, 5'd18, 32'h66, 1'b0, 5'd0, 32'd0);
    total++; if (a_ready !== 1'b1) begin bad++;
      $display("FAIL rmid_resume_ready: a=%b want 1", a_ready); end
    step();
    total++; if (reg_write_en !== 1'b1 || write_reg !== 5'd18 || write_data !== 32'h66) begin bad++;
      $display("FAIL rmid_resume: we=%b reg=%0d data=%0h want 1 18 66", reg_write_en, write_reg, write_data); end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    test_reset();
    test_a_only();
    test_conflict();
    test_starve();
    test_zero_reg();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
